uart_cmd_parser: RTL
====================

Name: uart_cmd_parser

Overview:
- Sits directly downstream of the UART receive core in TOP.
- Collects received ASCII bytes into a line, and on LF parses one of four commands: "rd AAAA", "wr AAAA DD", "stop" or "run".
- Executes the command on the internal register bus and returns an ASCII response through the UART transmit core.
- Also drives the global capture-stop control.

Parameters:
- LINE_MAX, 12, line buffer depth in characters (longest legal command is 10).
- ADDR_WIDTH, 16, register address width (exactly 4 hex digits).
- DATA_WIDTH, 8, register data width (exactly 2 hex digits).
- RD_TIMEOUT, 256, cycles to wait for read data before reporting an error.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- iRX_DE  in  1  one-cycle strobe: iRX_DATA holds a received byte.
- iRX_DATA  in  8  received byte (7-bit ASCII in bits 6:0; bit 7 ignored).
- oREG_WE  out  1  one-cycle register write strobe.
- oREG_RE  out  1  one-cycle register read strobe.
- oREG_ADDR  out  ADDR_WIDTH  register address, held from strobe until the next command.
- oREG_WDATA  out  DATA_WIDTH  write data, valid with oREG_WE.
- iREG_RDATA  in  DATA_WIDTH  read data, sampled when iREG_RVALID=1.
- iREG_RVALID  in  1  read data valid; may be high for one or more cycles.
- oTX_DE  out  1  transmit request, held high until iTX_BUSY is seen high.
- oTX_DATA  out  8  byte to transmit; stable while oTX_DE=1.
- iTX_BUSY  in  1  transmit core busy.
- oSTOP  out  1  capture stop level; set by "stop", cleared by "run".
- oCMD_ERR  out  1  one-cycle pulse on any rejected line.

Behaviour:
- Reset (async, any state):
  - state=COLLECT, line buffer and count=0, overflow flag=0.
  - All outputs 0, including oSTOP, oREG_ADDR, oREG_WDATA and oTX_DATA.
- States: COLLECT, PARSE, WR, RD_REQ, RD_WAIT, RESP, TX_REQ, TX_WAIT.
- COLLECT, per iRX_DE strobe:
  - 0x0D: ignored.
  - 0x08: count decrements if >0, otherwise ignored; overflow flag is not cleared.
  - 0x0A: count=0 -> ignored (no response); count>0 -> PARSE on the next cycle.
  - Any other byte: stored at index count, count++. At count=LINE_MAX the byte is dropped and overflow=1.
- PARSE (exactly 1 cycle), fields separated by exactly one 0x20, hex digits 0-9/A-F/a-f:
  - "rd"+sp+4 hex, count=7 -> RD_REQ.
  - "wr"+sp+4 hex+sp+2 hex, count=10 -> WR.
  - "stop", count=4 -> oSTOP=1, response "OK".
  - "run", count=3 -> oSTOP=0, response "OK".
  - Anything else, or overflow=1 -> oCMD_ERR pulse, response "NG".
  - Buffer, count and overflow clear on leaving PARSE.
- Strobe timing:
  - Cycle N = LF strobe, PARSE at N+1.
  - oREG_WE or oREG_RE is high exactly at N+2.
  - oREG_ADDR/oREG_WDATA are valid from N+2.
- WR: one-cycle oREG_WE, then response "OK".
- RD_REQ / RD_WAIT:
  - One-cycle oREG_RE, then wait for iREG_RVALID.
  - First RVALID cycle latches iREG_RDATA; response is two uppercase hex digits, MSB nibble first.
  - No RVALID within RD_TIMEOUT cycles after oREG_RE -> oCMD_ERR pulse, response "NG".
  - RVALID outside RD_WAIT is ignored.
- Response:
  - Bytes = payload then 0x0A ("OK"=4F 4B 0A, "NG"=4E 47 0A, read=hh hl 0A).
  - Up to 3 bytes, indexed by a 2-bit counter.
- TX handshake, per byte:
  - TX_REQ waits until iTX_BUSY=0, then drives oTX_DATA and oTX_DE=1.
  - oTX_DE holds until iTX_BUSY=1 is sampled, then drops.
  - TX_WAIT waits for iTX_BUSY=0, then moves to the next byte.
  - After the last byte -> COLLECT.
- iRX_DE strobes in any state other than COLLECT are dropped silently; no buffering, no error.
- Simultaneous iRX_DE with the PARSE transition: the byte is dropped.
- No state is retained across reset except through re-entry from COLLECT.

Test Plan:
1. "stop\n" (73 74 6F 70 0A) -> oSTOP=1; TX bytes 4F,4B,0A; no register strobes.
2. "wr 4002 FE\n" -> single oREG_WE at LF+2 cycles, oREG_ADDR=16'h4002, oREG_WDATA=8'hFE; TX 4F,4B,0A.
3. "rd 0001\n", iREG_RVALID=1 with iREG_RDATA=8'h3C three cycles after oREG_RE -> one oREG_RE, oREG_ADDR=16'h0001; TX 33,43,0A.
4. "rd" 08 08 "wr 0000 01\n" -> backspaces remove "rd"; oREG_WE addr 0000 data 01; TX "OK\n". Also a lone "\n" -> no output.
5. Error cases, each -> oCMD_ERR pulse, TX 4E,47,0A, no oREG_WE:
   - "wr 40G2 FE\n".
   - 13 non-LF bytes then LF (overflow).
   - "rd 0002\n" with iREG_RVALID held 0 for 256 cycles.
6. Reset mid-operation:
   - Assert RST while oTX_DE=1 -> all outputs 0 immediately, oSTOP=0.
   - After release, "run\n" -> TX "OK\n", oSTOP stays 0.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//   Collects ASCII bytes from the UART receiver into a line buffer and, on LF,
//   executes one of "rd AAAA", "wr AAAA DD", "stop" or "run" on the register
//   bus. Replies through the UART transmitter with "OK\n", "NG\n" or the two
//   uppercase hex digits of the read data followed by LF. Also owns the
//   global capture-stop level.
//
// Ports
//   CLK, RST              clock, asynchronous active-high reset
//   iRX_DE, iRX_DATA      received byte strobe / byte (bit 7 ignored)
//   oREG_WE, oREG_RE      one-cycle register write / read strobes
//   oREG_ADDR, oREG_WDATA register address (held) / write data
//   iREG_RDATA, iREG_RVALID read data and its valid
//   oTX_DE, oTX_DATA      transmit request (held until iTX_BUSY) / byte
//   iTX_BUSY              transmitter busy
//   oSTOP                 capture-stop level
//   oCMD_ERR              one-cycle pulse on a rejected line or read timeout
//
// state     | meaning
// ----------+-------------------------------------------------------------
// COLLECT   | gather bytes into the line buffer until LF
// PARSE     | decode the line (one cycle), latch address/data/response
// WR        | register write strobe
// RD_REQ    | register read strobe, arm timeout counter
// RD_WAIT   | wait for read data or timeout
// RESP      | rewind the response byte index
// TX_REQ    | present next response byte until transmitter goes busy
// TX_WAIT   | wait for transmitter idle, then next byte or back to COLLECT

module uart_cmd_parser #(
    parameter int LINE_MAX   = 12,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int RD_TIMEOUT = 256
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  iRX_DE,
    input  logic [7:0]            iRX_DATA,
    output logic                  oREG_WE,
    output logic                  oREG_RE,
    output logic [ADDR_WIDTH-1:0] oREG_ADDR,
    output logic [DATA_WIDTH-1:0] oREG_WDATA,
    input  logic [DATA_WIDTH-1:0] iREG_RDATA,
    input  logic                  iREG_RVALID,
    output logic                  oTX_DE,
    output logic [7:0]            oTX_DATA,
    input  logic                  iTX_BUSY,
    output logic                  oSTOP,
    output logic                  oCMD_ERR
);

    localparam int CW = $clog2(LINE_MAX + 1);
    localparam int TW = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_COLLECT,
        S_PARSE,
        S_WR,
        S_RD_REQ,
        S_RD_WAIT,
        S_RESP,
        S_TX_REQ,
        S_TX_WAIT
    } state_t;

    state_t state, state_nxt;

    logic [6:0]            line_buf [LINE_MAX];
    logic [CW-1:0]         cnt;
    logic                  ovf;
    logic [TW-1:0]         tmr;
    logic [7:0]            resp [3];
    logic [1:0]            resp_idx;
    logic [ADDR_WIDTH-1:0] reg_addr;
    logic [DATA_WIDTH-1:0] reg_wdata;
    logic                  reg_we, reg_re;
    logic                  tx_de;
    logic [7:0]            tx_data;
    logic                  stop_q;
    logic                  cmd_err;

    logic [6:0] rx_ch;
    logic       rx_lf, rx_cr, rx_bs;
    logic       unused_rx_msb;

    assign rx_ch         = iRX_DATA[6:0];
    assign rx_lf         = (rx_ch == 7'h0A);
    assign rx_cr         = (rx_ch == 7'h0D);
    assign rx_bs         = (rx_ch == 7'h08);
    assign unused_rx_msb = iRX_DATA[7];

    // {valid, nibble} for one ASCII hex digit, either case
    function automatic logic [4:0] hex_dec(input logic [6:0] c);
        if (c >= 7'h30 && c <= 7'h39)
            return {1'b1, c[3:0]};
        else if ((c >= 7'h41 && c <= 7'h46) || (c >= 7'h61 && c <= 7'h66))
            return {1'b1, c[3:0] + 4'd9};
        else
            return 5'b0;
    endfunction

    function automatic logic [7:0] nib_ascii(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else
            return 8'h37 + {4'h0, n};
    endfunction

    // Line decode; field positions are fixed because separators are single spaces
    logic [4:0]  h3, h4, h5, h6, h8, h9;
    logic [15:0] addr_p;
    logic [7:0]  data_p;
    logic [7:0]  rd_b;
    logic        addr_ok;
    logic        cmd_rd, cmd_wr, cmd_stop, cmd_run, cmd_bad;

    assign h3      = hex_dec(line_buf[3]);
    assign h4      = hex_dec(line_buf[4]);
    assign h5      = hex_dec(line_buf[5]);
    assign h6      = hex_dec(line_buf[6]);
    assign h8      = hex_dec(line_buf[8]);
    assign h9      = hex_dec(line_buf[9]);
    assign addr_p  = {h3[3:0], h4[3:0], h5[3:0], h6[3:0]};
    assign data_p  = {h8[3:0], h9[3:0]};
    assign addr_ok = h3[4] & h4[4] & h5[4] & h6[4];
    assign rd_b    = iREG_RDATA[7:0];

    assign cmd_rd   = (cnt == CW'(7)) && (line_buf[0] == 7'h72) && (line_buf[1] == 7'h64)
                      && (line_buf[2] == 7'h20) && addr_ok;
    assign cmd_wr   = (cnt == CW'(10)) && (line_buf[0] == 7'h77) && (line_buf[1] == 7'h72)
                      && (line_buf[2] == 7'h20) && addr_ok && (line_buf[7] == 7'h20)
                      && h8[4] && h9[4];
    assign cmd_stop = (cnt == CW'(4)) && (line_buf[0] == 7'h73) && (line_buf[1] == 7'h74)
                      && (line_buf[2] == 7'h6F) && (line_buf[3] == 7'h70);
    assign cmd_run  = (cnt == CW'(3)) && (line_buf[0] == 7'h72) && (line_buf[1] == 7'h75)
                      && (line_buf[2] == 7'h6E);
    assign cmd_bad  = ovf || !(cmd_rd || cmd_wr || cmd_stop || cmd_run);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= S_COLLECT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        reg_we    = 1'b0;
        reg_re    = 1'b0;
        case (state)
            S_COLLECT:
                if (iRX_DE && rx_lf && cnt != '0)
                    state_nxt = S_PARSE;
            S_PARSE:
                if (cmd_bad)
                    state_nxt = S_RESP;
                else if (cmd_rd)
                    state_nxt = S_RD_REQ;
                else if (cmd_wr)
                    state_nxt = S_WR;
                else
                    state_nxt = S_RESP;
            S_WR: begin
                reg_we    = 1'b1;
                state_nxt = S_RESP;
            end
            S_RD_REQ: begin
                reg_re    = 1'b1;
                state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT:
                if (iREG_RVALID || tmr == '0)
                    state_nxt = S_RESP;
            S_RESP:
                state_nxt = S_TX_REQ;
            S_TX_REQ:
                if (tx_de && iTX_BUSY)
                    state_nxt = S_TX_WAIT;
            S_TX_WAIT:
                if (!iTX_BUSY)
                    state_nxt = (resp_idx == 2'd2) ? S_COLLECT : S_TX_REQ;
            default:
                state_nxt = S_COLLECT;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < LINE_MAX; i++)
                line_buf[i] <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            tmr       <= '0;
            resp[0]   <= '0;
            resp[1]   <= '0;
            resp[2]   <= '0;
            resp_idx  <= '0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            tx_de     <= 1'b0;
            tx_data   <= '0;
            stop_q    <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            cmd_err <= 1'b0;
            case (state)
                S_COLLECT:
                    if (iRX_DE) begin
                        if (rx_bs) begin
                            if (cnt != '0)
                                cnt <= cnt - 1'b1;
                        end else if (!rx_cr && !rx_lf) begin
                            if (cnt == CW'(LINE_MAX)) begin
                                ovf <= 1'b1;
                            end else begin
                                line_buf[cnt] <= rx_ch;
                                cnt           <= cnt + 1'b1;
                            end
                        end
                    end
                S_PARSE: begin
                    for (int i = 0; i < LINE_MAX; i++)
                        line_buf[i] <= '0;
                    cnt <= '0;
                    ovf <= 1'b0;
                    if (cmd_bad) begin
                        cmd_err <= 1'b1;
                        resp[0] <= 8'h4E;
                        resp[1] <= 8'h47;
                        resp[2] <= 8'h0A;
                    end else if (cmd_rd) begin
                        reg_addr <= ADDR_WIDTH'(addr_p);
                    end else begin
                        if (cmd_wr) begin
                            reg_addr  <= ADDR_WIDTH'(addr_p);
                            reg_wdata <= DATA_WIDTH'(data_p);
                        end else begin
                            stop_q <= cmd_stop;
                        end
                        resp[0] <= 8'h4F;
                        resp[1] <= 8'h4B;
                        resp[2] <= 8'h0A;
                    end
                end
                S_RD_REQ:
                    tmr <= TW'(RD_TIMEOUT - 1);
                S_RD_WAIT:
                    if (iREG_RVALID) begin
                        resp[0] <= nib_ascii(rd_b[7:4]);
                        resp[1] <= nib_ascii(rd_b[3:0]);
                        resp[2] <= 8'h0A;
                    end else if (tmr == '0) begin
                        cmd_err <= 1'b1;
                        resp[0] <= 8'h4E;
                        resp[1] <= 8'h47;
                        resp[2] <= 8'h0A;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                S_RESP:
                    resp_idx <= '0;
                S_TX_REQ:
                    if (!tx_de) begin
                        if (!iTX_BUSY) begin
                            tx_de   <= 1'b1;
                            tx_data <= resp[resp_idx];
                        end
                    end else if (iTX_BUSY) begin
                        tx_de <= 1'b0;
                    end
                S_TX_WAIT:
                    if (!iTX_BUSY)
                        resp_idx <= resp_idx + 1'b1;
                default: begin
                end
            endcase
        end
    end

    assign oREG_WE    = reg_we;
    assign oREG_RE    = reg_re;
    assign oREG_ADDR  = reg_addr;
    assign oREG_WDATA = reg_wdata;
    assign oTX_DE     = tx_de;
    assign oTX_DATA   = tx_data;
    assign oSTOP      = stop_q;
    assign oCMD_ERR   = cmd_err;

endmodule
